// File: rtl/instr_mem_loader.sv
// Instruction memory with a runtime byte-stream program loader.
// Holds the CPU in reset (cpu_hold) while a program is being loaded.
module instr_mem_loader #(
  parameter int                 DEPTH      = 32,
  parameter int                 WIDTH      = 8,
  parameter int                 PC_W       = 8,
  parameter logic [WIDTH-1:0]   FILL_INSTR = {WIDTH{1'b0}},
  localparam int                AW         = $clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  output logic [WIDTH-1:0]  instr,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              load_end,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold,
  output logic [AW:0]       prog_len,
  output logic [1:0]        state
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int         CW       = (PC_W > AW + 1) ? PC_W : AW + 1;
  localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_LEN  = (AW + 1)'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [AW:0]      r_prog_len;
  logic [AW:0]      w_len_nxt;
  logic             r_load_err;
  logic             w_err_nxt;
  logic             r_load_ready;
  logic             r_load_done;
  logic             r_cpu_hold;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_ready;
  logic             w_accept;
  logic             w_reject;
  logic             w_last_slot;
  logic [AW-1:0]    w_wr_addr;
  logic [CW-1:0]    w_pc_ext;
  logic [CW-1:0]    w_len_ext;

  // The write pointer always equals the loaded length, so one counter serves both.
  assign w_ready     = (r_state == S_LOAD) && (r_prog_len < FULL_LEN);
  assign w_accept    = w_ready && load_valid && !load_start;
  assign w_reject    = load_valid && !w_ready && ((r_state == S_LOAD) || (r_state == S_DONE));
  assign w_last_slot = (r_prog_len == (FULL_LEN - ONE_LEN));
  assign w_wr_addr   = r_prog_len[AW-1:0];

  // Next-state, length and sticky-error decode; load_start outranks everything.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_prog_len;
    w_err_nxt   = r_load_err;
    if (load_start) begin
      w_state_nxt = S_LOAD;
      w_len_nxt   = '0;
      w_err_nxt   = 1'b0;
    end else begin
      if (w_reject) begin
        w_err_nxt = 1'b1;
      end else begin
        w_err_nxt = r_load_err;
      end
      case (r_state)
        S_HALT: begin
          if (run_start) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_HALT;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            w_len_nxt = r_prog_len + ONE_LEN;
          end else begin
            w_len_nxt = r_prog_len;
          end
          if (load_end || (w_accept && w_last_slot)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
        S_DONE: begin
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_HALT;
        end
      endcase
    end
  end

  // Control registers, including output flags decoded ahead from the next state.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      r_state      <= S_HALT;
      r_prog_len   <= '0;
      r_load_err   <= 1'b0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_prog_len   <= w_len_nxt;
      r_load_err   <= w_err_nxt;
      r_load_ready <= (w_state_nxt == S_LOAD) && (w_len_nxt < FULL_LEN);
      r_load_done  <= (w_state_nxt == S_DONE);
      r_cpu_hold   <= (w_state_nxt != S_RUN);
    end
  end

  // Program storage: reset wipes any partial program back to the fill value.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= FILL_INSTR;
      end
    end else if (w_accept) begin
      r_mem[w_wr_addr] <= load_data;
    end
  end

  // Zero-latency fetch; stale words beyond prog_len are masked, not cleared.
  always_comb begin
    w_pc_ext  = CW'(pc);
    w_len_ext = CW'(r_prog_len);
    if ((r_state == S_RUN) && (w_pc_ext < w_len_ext)) begin
      instr = r_mem[w_pc_ext[AW-1:0]];
    end else begin
      instr = FILL_INSTR;
    end
  end

  assign load_ready = r_load_ready;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign cpu_hold   = r_cpu_hold;
  assign prog_len   = r_prog_len;
  assign state      = r_state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a behavioural model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_instr_mem_loader;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int PC_W  = 8;
  localparam logic [7:0] FILL = 8'h00;

  localparam int S_HALT = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;
  localparam int S_RUN  = 3;

  logic            clk_50m = 1'b0;
  logic            reset   = 1'b1;
  logic [PC_W-1:0] pc      = '0;
  logic [7:0]      instr;
  logic            load_start = 1'b0;
  logic            run_start  = 1'b0;
  logic            load_valid = 1'b0;
  logic [7:0]      load_data  = '0;
  logic            load_end   = 1'b0;
  logic            load_ready;
  logic            load_done;
  logic            load_err;
  logic            cpu_hold;
  logic [5:0]      prog_len;
  logic [1:0]      state;

  instr_mem_loader #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .PC_W(PC_W), .FILL_INSTR(FILL)
  ) dut (
    .clk_50m(clk_50m), .reset(reset), .pc(pc), .instr(instr),
    .load_start(load_start), .run_start(run_start), .load_valid(load_valid),
    .load_data(load_data), .load_end(load_end), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .cpu_hold(cpu_hold),
    .prog_len(prog_len), .state(state)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct {
    int         st;
    bit         hold;
    bit         ready;
    bit         done;
    bit         err;
    int         len;
    logic [7:0] ins;
    int         pcv;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: program as an array plus a length and a mode.
  int         m_state;
  int         m_len;
  bit         m_err;
  logic [7:0] m_mem [DEPTH];

  function automatic void m_reset();
    m_state = S_HALT;
    m_len   = 0;
    m_err   = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.st    = m_state;
    e.hold  = (m_state != S_RUN);
    e.ready = (m_state == S_LOAD) && (m_len < DEPTH);
    e.done  = (m_state == S_DONE);
    e.err   = m_err;
    e.len   = m_len;
    e.pcv   = int'(pc);
    if (m_state == S_RUN && int'(pc) < m_len) e.ins = m_mem[int'(pc)];
    else e.ins = FILL;
    return e;
  endfunction

  function automatic void m_advance();
    bit accepting;
    accepting = (m_state == S_LOAD) && (m_len < DEPTH);
    if (load_start) begin
      m_err   = 1'b0;
      m_state = S_LOAD;
      m_len   = 0;
    end else begin
      if (load_valid && !accepting && (m_state == S_LOAD || m_state == S_DONE))
        m_err = 1'b1;
      case (m_state)
        S_HALT: if (run_start) m_state = S_RUN;
        S_LOAD: begin
          if (load_valid && accepting) begin
            m_mem[m_len] = load_data;
            m_len = m_len + 1;
          end
          if (load_end || m_len == DEPTH) m_state = S_DONE;
        end
        S_DONE: m_state = S_RUN;
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    if (!reset) m_reset();
    sb_q.push_back(m_expect());
    if (reset) m_advance();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic d(input bit ls, input bit rs, input bit lv, input logic [7:0] dat,
                   input bit le, input logic [7:0] p);
    load_start = ls;
    run_start  = rs;
    load_valid = lv;
    load_data  = dat;
    load_end   = le;
    pc         = p;
    step();
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int p);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual %0h expected %0h (pc=%0d t=%0t)", name, act, exp_v, p, $time);
    end
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk_50m) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("state",      32'(state),      32'(e.st),    e.pcv);
      chk("cpu_hold",   32'(cpu_hold),   32'(e.hold),  e.pcv);
      chk("load_ready", 32'(load_ready), 32'(e.ready), e.pcv);
      chk("load_done",  32'(load_done),  32'(e.done),  e.pcv);
      chk("load_err",   32'(load_err),   32'(e.err),   e.pcv);
      chk("prog_len",   32'(prog_len),   32'(e.len),   e.pcv);
      chk("instr",      32'(instr),      32'(e.ins),   e.pcv);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] w;
    bit         ls;
    m_reset();
    #2 reset = 1'b0;
    @(posedge clk_50m); #1;
    d(0, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd5);
    reset = 1'b1;

    // Empty memory, held CPU.
    for (int p = 0; p < 32; p++) d(0, 0, 0, 8'h00, 0, 8'(p));

    // Three-word program ending with load_end.
    d(1, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 1, 8'h49, 0, 8'd0);
    d(0, 0, 1, 8'hC1, 0, 8'd0);
    d(0, 0, 1, 8'h18, 1, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd1);
    d(0, 0, 0, 8'h00, 0, 8'd3);
    d(0, 0, 0, 8'h00, 0, 8'd2);

    // Reload a single word from RUN; old words beyond it are masked.
    d(1, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 1, 8'hA9, 1, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 0, 8'h00, 0, 8'd1);

    // Overflow: 33 words, no load_end.
    d(1, 0, 0, 8'h00, 0, 8'd0);
    for (int i = 0; i < 33; i++) begin
      w = 8'($urandom_range(0, 255));
      d(0, 0, 1, w, 0, 8'd0);
    end
    for (int p = 0; p < 34; p++) d(0, 0, 0, 8'h00, 0, 8'(p));

    // Reset in the middle of a load.
    d(1, 0, 0, 8'h00, 0, 8'd0);
    d(0, 0, 1, 8'h11, 0, 8'd0);
    d(0, 0, 1, 8'h22, 0, 8'd0);
    reset = 1'b0;
    d(0, 0, 1, 8'h33, 0, 8'd0);
    reset = 1'b1;
    d(0, 0, 0, 8'h00, 0, 8'd0);

    // run_start without a program.
    d(0, 1, 0, 8'h00, 0, 8'd0);
    for (int p = 0; p < 32; p++) d(0, 0, 0, 8'h00, 0, 8'(p));
    d(0, 0, 0, 8'h00, 0, 8'd200);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      ls = (m_state != S_DONE) && ($urandom_range(0, 99) < 3);
      reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      d(ls, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60,
        8'($urandom_range(0, 255)), $urandom_range(0, 99) < 6,
        ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, 35)) : 8'($urandom_range(0, 255)));
    end
    reset = 1'b1;

    @(negedge clk_50m); #1;
    chk("queue_drain", 32'(sb_q.size()), 32'd0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
